// File: rtl/me_sched_pkg.sv
// Shared types for the CTU scheduler: main FSM encoding and default coordinate width.
package me_sched_pkg;

  localparam int CTU_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    PREP   = 3'd2,
    SEARCH = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ctu_raster_cnt.sv
// Raster-order CTU coordinate register with clear/advance and a combinational
// look-ahead of the following CTU for window prefetch.
module ctu_raster_cnt
  import me_sched_pkg::*;
#(
  parameter int CTU_W = CTU_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [CTU_W-1:0] cols,
  input  logic [CTU_W-1:0] rows,
  output logic [CTU_W-1:0] x,
  output logic [CTU_W-1:0] y,
  output logic [CTU_W-1:0] nxt_x,
  output logic [CTU_W-1:0] nxt_y,
  output logic             is_last
);

  logic [CTU_W-1:0] x_q, x_d;
  logic [CTU_W-1:0] y_q, y_d;
  logic             last_col_s;

  // Next-CTU look-ahead and register update
  always_comb begin
    last_col_s = (x_q == (cols - CTU_W'(1)));
    nxt_x      = last_col_s ? {CTU_W{1'b0}} : (x_q + CTU_W'(1));
    nxt_y      = last_col_s ? (y_q + CTU_W'(1)) : y_q;
    is_last    = last_col_s && (y_q == (rows - CTU_W'(1)));
    if (clr) begin
      x_d = {CTU_W{1'b0}};
      y_d = {CTU_W{1'b0}};
    end else if (adv) begin
      x_d = nxt_x;
      y_d = nxt_y;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Coordinate registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= {CTU_W{1'b0}};
      y_q <= {CTU_W{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/me_ctu_scheduler.sv
// Frame-level CTU scheduler: raster walk, ping-pong window fetch with one-ahead
// prefetch, PE array kick-off and MV result handshake.
module me_ctu_scheduler
  import me_sched_pkg::*;
#(
  parameter int CTU_W  = CTU_W_DEF,
  parameter int CB_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CTU_W-1:0] frame_cols,
  input  logic [CTU_W-1:0] frame_rows,
  output logic             ld_req,
  output logic [CTU_W-1:0] ld_x,
  output logic [CTU_W-1:0] ld_y,
  output logic             ld_bank,
  input  logic             ld_ack,
  output logic             begin_prepare,
  output logic             cur_bank,
  input  logic             me_done,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [CTU_W-1:0] cur_x,
  output logic [CTU_W-1:0] cur_y,
  output logic             busy,
  output logic             frame_done
);

  // CB_CNT only sizes result tags downstream; nothing here depends on it.
  if (CB_CNT < 1) begin : g_cb_cnt_unused
  end

  state_e           state_q, state_d;
  logic [CTU_W-1:0] cols_q, cols_d, rows_q, rows_d;
  logic [CTU_W-1:0] ld_x_q, ld_x_d, ld_y_q, ld_y_d;
  logic             ld_req_q, ld_req_d, ld_bank_q, ld_bank_d;
  logic             cur_bank_q, cur_bank_d;
  logic             pf_out_q, pf_out_d, pf_acked_q, pf_acked_d;
  logic             bp_q, bp_d, mv_valid_q, mv_valid_d;
  logic             busy_q, busy_d, frame_done_q, frame_done_d;
  logic             ack_s, cnt_clr_s, cnt_adv_s, cnt_last_s;
  logic [CTU_W-1:0] nxt_x_s, nxt_y_s;

  ctu_raster_cnt #(.CTU_W(CTU_W)) u_cur (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr_s),
    .adv     (cnt_adv_s),
    .cols    (cols_q),
    .rows    (rows_q),
    .x       (cur_x),
    .y       (cur_y),
    .nxt_x   (nxt_x_s),
    .nxt_y   (nxt_y_s),
    .is_last (cnt_last_s)
  );

  // Next state, load request bookkeeping and registered output values
  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    ld_req_d   = ld_req_q;
    ld_x_d     = ld_x_q;
    ld_y_d     = ld_y_q;
    ld_bank_d  = ld_bank_q;
    cur_bank_d = cur_bank_q;
    pf_out_d   = pf_out_q;
    pf_acked_d = pf_acked_q;
    cnt_clr_s  = 1'b0;
    cnt_adv_s  = 1'b0;
    ack_s      = ld_ack & ld_req_q;

    if (abort) begin
      state_d    = IDLE;
      ld_req_d   = 1'b0;
      ld_x_d     = {CTU_W{1'b0}};
      ld_y_d     = {CTU_W{1'b0}};
      ld_bank_d  = 1'b0;
      cur_bank_d = 1'b0;
      pf_out_d   = 1'b0;
      pf_acked_d = 1'b0;
      cnt_clr_s  = 1'b1;
    end else begin
      if (ack_s) begin
        ld_req_d   = 1'b0;
        pf_out_d   = 1'b0;
        pf_acked_d = pf_acked_q | pf_out_q;
      end else begin
        ld_req_d = ld_req_q;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = FETCH;
            cols_d     = (frame_cols == {CTU_W{1'b0}}) ? CTU_W'(1) : frame_cols;
            rows_d     = (frame_rows == {CTU_W{1'b0}}) ? CTU_W'(1) : frame_rows;
            cnt_clr_s  = 1'b1;
            cur_bank_d = 1'b0;
            ld_req_d   = 1'b1;
            ld_x_d     = {CTU_W{1'b0}};
            ld_y_d     = {CTU_W{1'b0}};
            ld_bank_d  = 1'b0;
            pf_out_d   = 1'b0;
            pf_acked_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        FETCH:  state_d = ack_s ? PREP : FETCH;
        PREP: begin
          state_d = SEARCH;
          if (!cnt_last_s) begin
            ld_req_d  = 1'b1;
            ld_x_d    = nxt_x_s;
            ld_y_d    = nxt_y_s;
            ld_bank_d = ~cur_bank_q;
            pf_out_d  = 1'b1;
          end else begin
            pf_out_d = 1'b0;
          end
        end
        SEARCH: state_d = me_done ? FLUSH : SEARCH;
        FLUSH: begin
          if (!mv_ready) begin
            state_d = FLUSH;
          end else if (cnt_last_s) begin
            state_d = DONE;
          end else begin
            // A prefetch ack landing on the handshake edge counts as already acked.
            state_d    = (pf_acked_q | ack_s) ? PREP : FETCH;
            cnt_adv_s  = 1'b1;
            cur_bank_d = ~cur_bank_q;
            pf_acked_d = 1'b0;
            pf_out_d   = 1'b0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    bp_d         = (state_d == PREP);
    mv_valid_d   = (state_d == FLUSH);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cols_q       <= CTU_W'(1);
      rows_q       <= CTU_W'(1);
      ld_req_q     <= 1'b0;
      ld_x_q       <= {CTU_W{1'b0}};
      ld_y_q       <= {CTU_W{1'b0}};
      ld_bank_q    <= 1'b0;
      cur_bank_q   <= 1'b0;
      pf_out_q     <= 1'b0;
      pf_acked_q   <= 1'b0;
      bp_q         <= 1'b0;
      mv_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      ld_req_q     <= ld_req_d;
      ld_x_q       <= ld_x_d;
      ld_y_q       <= ld_y_d;
      ld_bank_q    <= ld_bank_d;
      cur_bank_q   <= cur_bank_d;
      pf_out_q     <= pf_out_d;
      pf_acked_q   <= pf_acked_d;
      bp_q         <= bp_d;
      mv_valid_q   <= mv_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ld_req        = ld_req_q;
  assign ld_x          = ld_x_q;
  assign ld_y          = ld_y_q;
  assign ld_bank       = ld_bank_q;
  assign begin_prepare = bp_q;
  assign cur_bank      = cur_bank_q;
  assign mv_valid      = mv_valid_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_me_ctu_scheduler.sv
// Directed testbench for me_ctu_scheduler; each scenario task checks its own
// cycle-exact expectations right after the active clock edge.
module tb_me_ctu_scheduler;

  logic       clk, rst_n, start, abort, ld_ack, me_done, mv_ready;
  logic [7:0] frame_cols, frame_rows;
  logic       ld_req, ld_bank, begin_prepare, cur_bank, mv_valid, busy, frame_done;
  logic [7:0] ld_x, ld_y, cur_x, cur_y;
  wire [38:0] all_outs = {ld_req, ld_x, ld_y, ld_bank, begin_prepare, cur_bank,
                          mv_valid, cur_x, cur_y, busy, frame_done};

  int checks = 0;
  int passed = 0;

  me_ctu_scheduler #(.CTU_W(8), .CB_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_cols(frame_cols), .frame_rows(frame_rows),
    .ld_req(ld_req), .ld_x(ld_x), .ld_y(ld_y), .ld_bank(ld_bank), .ld_ack(ld_ack),
    .begin_prepare(begin_prepare), .cur_bank(cur_bank), .me_done(me_done),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .cur_x(cur_x), .cur_y(cur_y),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_ack = 1'b0;
    me_done = 1'b0; mv_ready = 1'b0; frame_cols = 8'd0; frame_rows = 8'd0;
    tick(); tick();
    checks++;
    if (all_outs !== 39'd0) $display("FAIL reset_outs: got %h expected 0", all_outs);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  // Zero dimensions are forced to 1, giving a 1x1 frame
  task automatic test_single();
    frame_cols = 8'd0; frame_rows = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({ld_req, ld_x, ld_y, ld_bank, busy} !== {1'b1, 8'd0, 8'd0, 1'b0, 1'b1})
      $display("FAIL single_load: got %b/%0d/%0d/%b/%b expected 1/0/0/0/1", ld_req, ld_x, ld_y, ld_bank, busy);
    else passed++;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    checks++;
    if ({begin_prepare, ld_req, cur_x, cur_y, cur_bank} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0})
      $display("FAIL single_prep: got bp=%b req=%b cur=(%0d,%0d) bank=%b expected 1 0 (0,0) 0", begin_prepare, ld_req, cur_x, cur_y, cur_bank);
    else passed++;
    tick();
    checks++;
    if ({begin_prepare, ld_req, busy} !== 3'b001)
      $display("FAIL single_no_prefetch: got bp=%b req=%b busy=%b expected 0 0 1", begin_prepare, ld_req, busy);
    else passed++;
    me_done = 1'b1; tick(); me_done = 1'b0;
    checks++;
    if ({mv_valid, frame_done} !== 2'b10)
      $display("FAIL single_mv_valid: got %b%b expected 10", mv_valid, frame_done);
    else passed++;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if ({mv_valid, frame_done, busy} !== 3'b011)
      $display("FAIL single_frame_done: got %b%b%b expected 011", mv_valid, frame_done, busy);
    else passed++;
    tick();
    checks++;
    if ({frame_done, busy} !== 2'b00)
      $display("FAIL single_idle: got %b%b expected 00", frame_done, busy);
    else passed++;
  endtask

  // 3x2 frame, prefetch acked with me_done, mv_ready held: pulses every 3 cycles
  task automatic test_raster();
    frame_cols = 8'd3; frame_rows = 8'd2; mv_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({begin_prepare, cur_x, cur_y, cur_bank, mv_valid} !== {1'b1, 8'(i % 3), 8'(i / 3), 1'(i % 2), 1'b0})
        $display("FAIL raster_prep_%0d: got bp=%b cur=(%0d,%0d) bank=%b mv=%b expected 1 (%0d,%0d) %0d 0",
                 i, begin_prepare, cur_x, cur_y, cur_bank, mv_valid, i % 3, i / 3, i % 2);
      else passed++;
      tick();
      checks++;
      if (i < 5) begin
        if ({begin_prepare, ld_req, ld_x, ld_y, ld_bank} !== {1'b0, 1'b1, 8'((i + 1) % 3), 8'((i + 1) / 3), 1'((i + 1) % 2)})
          $display("FAIL raster_prefetch_%0d: got bp=%b req=%b (%0d,%0d) bank=%b expected 0 1 (%0d,%0d) %0d",
                   i, begin_prepare, ld_req, ld_x, ld_y, ld_bank, (i + 1) % 3, (i + 1) / 3, (i + 1) % 2);
        else passed++;
      end else begin
        if ({begin_prepare, ld_req} !== 2'b00)
          $display("FAIL raster_last_no_prefetch: got bp=%b req=%b expected 0 0", begin_prepare, ld_req);
        else passed++;
      end
      ld_ack = (i < 5); me_done = 1'b1; tick(); ld_ack = 1'b0; me_done = 1'b0;
      checks++;
      if ({begin_prepare, mv_valid, ld_req} !== 3'b010)
        $display("FAIL raster_flush_%0d: got bp=%b mv=%b req=%b expected 0 1 0", i, begin_prepare, mv_valid, ld_req);
      else passed++;
      tick();
    end
    checks++;
    if ({frame_done, busy, begin_prepare} !== 3'b110)
      $display("FAIL raster_done: got fd=%b busy=%b bp=%b expected 1 1 0", frame_done, busy, begin_prepare);
    else passed++;
    mv_ready = 1'b0;
    tick();
    checks++;
    if ({frame_done, busy} !== 2'b00)
      $display("FAIL raster_idle: got %b%b expected 00", frame_done, busy);
    else passed++;
  endtask

  // Prefetch ack arrives 20 cycles after the handshake; FSM dwells in FETCH
  task automatic test_delayed_ack();
    logic bp_seen;
    frame_cols = 8'd2; frame_rows = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if ({ld_req, ld_x, ld_bank, cur_x, cur_bank, mv_valid, begin_prepare} !== {1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0})
      $display("FAIL delay_fetch: got req=%b ldx=%0d ldb=%b cur=%0d cb=%b mv=%b bp=%b expected 1 1 1 1 1 0 0",
               ld_req, ld_x, ld_bank, cur_x, cur_bank, mv_valid, begin_prepare);
    else passed++;
    bp_seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      bp_seen = bp_seen | begin_prepare;
    end
    checks++;
    if ({bp_seen, ld_req, busy} !== 3'b011)
      $display("FAIL delay_wait: got bp_seen=%b req=%b busy=%b expected 0 1 1", bp_seen, ld_req, busy);
    else passed++;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    checks++;
    if ({begin_prepare, ld_req} !== 2'b10)
      $display("FAIL delay_prep: got bp=%b req=%b expected 1 0", begin_prepare, ld_req);
    else passed++;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if (frame_done !== 1'b1) $display("FAIL delay_frame_done: got %b expected 1", frame_done);
    else passed++;
    tick();
  endtask

  // Prefetch ack on the same edge as the handshake goes straight to PREP
  task automatic test_coincident_ack();
    frame_cols = 8'd2; frame_rows = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    ld_ack = 1'b1; mv_ready = 1'b1; tick(); ld_ack = 1'b0; mv_ready = 1'b0;
    checks++;
    if ({begin_prepare, ld_req, cur_x, cur_bank} !== {1'b1, 1'b0, 8'd1, 1'b1})
      $display("FAIL coinc_prep: got bp=%b req=%b cur_x=%0d cb=%b expected 1 0 1 1", begin_prepare, ld_req, cur_x, cur_bank);
    else passed++;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if ({frame_done, busy} !== 2'b11) $display("FAIL coinc_frame_done: got %b%b expected 11", frame_done, busy);
    else passed++;
    tick();
  endtask

  // mv_ready withheld; stray start and me_done during FLUSH have no effect
  task automatic test_stall();
    frame_cols = 8'd1; frame_rows = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); me_done = (i == 6);
      checks++;
      if ({mv_valid, busy, begin_prepare, ld_req} !== 4'b1100)
        $display("FAIL stall_%0d: got mv=%b busy=%b bp=%b req=%b expected 1 1 0 0", i, mv_valid, busy, begin_prepare, ld_req);
      else passed++;
      tick();
    end
    start = 1'b0; me_done = 1'b0;
    checks++;
    if ({mv_valid, frame_done} !== 2'b10) $display("FAIL stall_hold: got %b%b expected 10", mv_valid, frame_done);
    else passed++;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if ({mv_valid, frame_done} !== 2'b01) $display("FAIL stall_release: got %b%b expected 01", mv_valid, frame_done);
    else passed++;
    tick();
  endtask

  // Abort mid-SEARCH with a prefetch outstanding, then a clean restart
  task automatic test_abort();
    frame_cols = 8'd2; frame_rows = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    tick();
    checks++;
    if ({ld_req, ld_x, ld_bank} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL abort_pf_out: got req=%b ldx=%0d ldb=%b expected 1 1 1", ld_req, ld_x, ld_bank);
    else passed++;
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (all_outs !== 39'd0) $display("FAIL abort_outs: got %h expected 0", all_outs);
    else passed++;
    ld_ack = 1'b1; me_done = 1'b1; tick(); ld_ack = 1'b0; me_done = 1'b0;
    checks++;
    if (all_outs !== 39'd0) $display("FAIL abort_stray_inputs: got %h expected 0", all_outs);
    else passed++;
    frame_cols = 8'd1; frame_rows = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({ld_req, ld_x, ld_y, ld_bank, cur_x, cur_y, cur_bank, busy} !== {1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1})
      $display("FAIL abort_restart: got req=%b (%0d,%0d) ldb=%b cur=(%0d,%0d) cb=%b busy=%b expected 1 (0,0) 0 (0,0) 0 1",
               ld_req, ld_x, ld_y, ld_bank, cur_x, cur_y, cur_bank, busy);
    else passed++;
    ld_ack = 1'b1; tick(); ld_ack = 1'b0;
    checks++;
    if ({begin_prepare, cur_bank} !== 2'b10) $display("FAIL abort_restart_prep: got bp=%b cb=%b expected 1 0", begin_prepare, cur_bank);
    else passed++;
    tick();
    me_done = 1'b1; tick(); me_done = 1'b0;
    mv_ready = 1'b1; tick(); mv_ready = 1'b0;
    checks++;
    if (frame_done !== 1'b1) $display("FAIL abort_restart_done: got %b expected 1", frame_done);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_raster();
    test_delayed_ack();
    test_coincident_ack();
    test_stall();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
